// File: rtl/reg_sched_pkg.sv
// Shared types and default sizing for the register-file write scheduler.
package reg_sched_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam int unsigned N_REQ_DEF     = 16;
  localparam int unsigned DATA_W_DEF    = 16;
  localparam int unsigned ADDR_W_DEF    = 4;
  localparam int unsigned MAX_BURST_DEF = 4;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: first set request at or after ptr, wrapping.
module rr_picker #(
  parameter int unsigned N  = 16,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [IW-1:0] cand;

  // N is a power of two, so the IW-bit add wraps modulo N for free.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    cand    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = ptr_i + IW'(k);
      if (!any_o && req_i[cand]) begin
        any_o = 1'b1;
        idx_o = cand;
      end
    end
    if (any_o) grant_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/reg_write_scheduler.sv
// Round-robin arbiter for the shared register-file write port with bounded
// burst locking and a registered write bus.
module reg_write_scheduler
  import reg_sched_pkg::*;
#(
  parameter int unsigned N_REQ     = N_REQ_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned MAX_BURST = MAX_BURST_DEF,
  localparam int unsigned IDW      = $clog2(N_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         lock,
  input  logic [N_REQ*ADDR_W-1:0]  req_addr,
  input  logic [N_REQ*DATA_W-1:0]  req_data,
  input  logic                     stall,
  output logic [N_REQ-1:0]         ack,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [DATA_W-1:0]        wr_data,
  output logic                     owner_valid,
  output logic [IDW-1:0]           owner_id
);

  localparam int unsigned    BCW     = $clog2(MAX_BURST) + 1;
  localparam logic [BCW-1:0] BMAX    = BCW'(MAX_BURST);
  localparam bit             LOCK_EN = (MAX_BURST > 1);

  state_e             state_q, state_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [BCW-1:0]     bcnt_q, bcnt_d, bcnt_inc;
  logic [IDW-1:0]     owner_q, owner_d;
  logic               wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]  wr_data_q, wr_data_d;

  logic [N_REQ-1:0]   pick_grant;
  logic [IDW-1:0]     pick_idx;
  logic               pick_any;
  logic               acc;
  logic [IDW-1:0]     acc_idx;

  rr_picker #(.N(N_REQ), .IW(IDW)) u_picker (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      bcnt_q    <= '0;
      owner_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      bcnt_q    <= bcnt_d;
      owner_q   <= owner_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Arbitration FSM; stall or reset freezes all state and suppresses ack.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    bcnt_d   = bcnt_q;
    owner_d  = owner_q;
    ack      = '0;
    acc      = 1'b0;
    acc_idx  = pick_idx;
    bcnt_inc = bcnt_q + BCW'(1);
    if (rst && !stall) begin
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            acc   = 1'b1;
            ack   = pick_grant;
            ptr_d = pick_idx + IDW'(1);
            if (LOCK_EN && lock[pick_idx]) begin
              state_d = LOCKED;
              owner_d = pick_idx;
              bcnt_d  = BCW'(1);
            end
          end
        end
        LOCKED: begin
          acc_idx = owner_q;
          if (req[owner_q]) begin
            acc          = 1'b1;
            ack[owner_q] = 1'b1;
            bcnt_d       = bcnt_inc;
            // Reaching the burst limit releases even if lock is still high.
            if (!lock[owner_q] || (bcnt_inc == BMAX)) begin
              state_d = IDLE;
              owner_d = '0;
              bcnt_d  = '0;
            end
          end else begin
            state_d = IDLE;
            owner_d = '0;
            bcnt_d  = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    wr_en_d   = acc;
    wr_addr_d = acc ? req_addr[acc_idx*ADDR_W +: ADDR_W] : wr_addr_q;
    wr_data_d = acc ? req_data[acc_idx*DATA_W +: DATA_W] : wr_data_q;
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign owner_valid = (state_q == LOCKED);
  assign owner_id    = owner_q;

endmodule

// File: tb/tb_reg_write_scheduler.sv
// Scoreboard bench for reg_write_scheduler: directed scenarios plus random
// traffic checked against a behavioural arbitration model.
module tb_reg_write_scheduler;

  localparam int N  = 16;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam int MB = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req, lock, ack;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_data;
  logic              stall;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic              owner_valid;
  logic [3:0]        owner_id;

  always #5 clk = ~clk;

  reg_write_scheduler #(.N_REQ(N), .DATA_W(DW), .ADDR_W(AW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .req_addr(req_addr),
    .req_data(req_data), .stall(stall), .ack(ack), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .owner_valid(owner_valid),
    .owner_id(owner_id)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  int  checks = 0;
  int  errors = 0;
  wr_t exp_q[$];
  wr_t mon_e;

  // Requester-side state: a pending request holds until acked, possibly for several beats.
  bit            pend[N];
  bit            lk[N];
  int            remain[N];
  int            gap[N];
  logic [AW-1:0] p_addr[N];
  logic [DW-1:0] p_data[N];
  bit            stall_v;
  bit            rand_mode;
  logic [N-1:0]  last_ack;

  int m_ptr, m_owner, m_beats;
  bit m_locked;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_grant();
    if (!rst || stall) return -1;
    if (m_locked) return req[m_owner] ? m_owner : -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (req[i]) return i;
    end
    return -1;
  endfunction

  function automatic void model_edge(input int g);
    if (!rst || stall) return;
    if (m_locked) begin
      if (g < 0) m_locked = 0;
      else begin
        m_beats++;
        if (!lock[g] || m_beats >= MB) m_locked = 0;
      end
    end else if (g >= 0) begin
      m_ptr = (g + 1) % N;
      if (lock[g] && MB > 1) begin
        m_locked = 1;
        m_owner  = g;
        m_beats  = 1;
      end
    end
  endfunction

  task automatic clr_all();
    for (int i = 0; i < N; i++) begin
      pend[i] = 0; lk[i] = 0; remain[i] = 0; gap[i] = 0;
    end
  endtask

  task automatic raise(input int i, input bit l, input int beats);
    pend[i]   = 1;
    lk[i]     = l;
    remain[i] = beats;
    gap[i]    = 0;
    p_addr[i] = AW'($urandom_range(0, N - 1));
    p_data[i] = DW'($urandom);
  endtask

  // One clock cycle: drive at negedge, predict ack and write, advance model after posedge.
  task automatic step();
    int g;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      req[i]               = pend[i];
      lock[i]              = pend[i] && lk[i] && (remain[i] > 1);
      req_addr[i*AW +: AW] = p_addr[i];
      req_data[i*DW +: DW] = p_data[i];
    end
    stall = stall_v;
    #1;
    g = model_grant();
    last_ack = ack;
    chk("ack", ack, (g >= 0) ? (32'd1 << g) : 32'd0);
    if (g >= 0) exp_q.push_back({p_addr[g], p_data[g]});
    @(posedge clk);
    #1;
    model_edge(g);
    if (g >= 0) begin
      remain[g]--;
      if (remain[g] <= 0) pend[g] = 0;
      else begin
        p_addr[g] = AW'($urandom_range(0, N - 1));
        p_data[g] = DW'($urandom);
        if (rand_mode && $urandom_range(0, 3) == 0) begin
          pend[g] = 0;
          gap[g]  = $urandom_range(1, 2);
        end
      end
    end
    chk("owner_valid", owner_valid, m_locked);
    chk("owner_id", owner_id, m_locked ? m_owner : 0);
  endtask

  // Asynchronous reset applied between edges; in-flight writes are dropped.
  task automatic do_reset();
    #1;
    rst = 1'b0;
    exp_q.delete();
    m_ptr = 0; m_locked = 0; m_owner = 0; m_beats = 0;
    req = '1;
    #1;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_owner_valid", owner_valid, 0);
    chk("rst_owner_id", owner_id, 0);
    chk("rst_ack", ack, 0);
    clr_all();
    @(posedge clk);
    #2;
    rst = 1'b1;
  endtask

  // Every expected write must appear exactly one cycle after its acceptance.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("wr_en", wr_en, 1);
        chk("wr_addr", wr_addr, mon_e.a);
        chk("wr_data", wr_data, mon_e.d);
      end else begin
        chk("wr_en_idle", wr_en, 0);
      end
    end
  end

  initial begin
    rst = 1'b1; req = '0; lock = '0; req_addr = '0; req_data = '0; stall = 1'b0;
    stall_v = 0; rand_mode = 0; last_ack = '0;
    clr_all();
    do_reset();

    // Two held requests from ptr=0.
    raise(3, 0, 1); raise(7, 0, 1);
    step(); chk("first_ack3", last_ack, 32'h0008);
    step(); chk("then_ack7", last_ack, 32'h0080);
    step(); step();

    // All requesters active, data = ID, requester 0 served twice.
    for (int i = 0; i < N; i++) begin
      raise(i, 0, (i == 0) ? 2 : 1);
      p_data[i] = DW'(i);
      p_addr[i] = AW'(i);
    end
    repeat (18) step();

    // Burst from 5 capped at MAX_BURST while 2 waits.
    raise(5, 1, 6);
    step();
    raise(2, 0, 1);
    repeat (9) step();

    // Stall holds off a pending request.
    raise(1, 0, 1);
    stall_v = 1;
    repeat (3) step();
    stall_v = 0;
    repeat (2) step();

    // Reset in the middle of a locked burst, then arbitration restarts at 0.
    raise(9, 1, 5);
    step(); step();
    do_reset();
    raise(0, 0, 1); raise(9, 0, 1);
    step(); chk("post_rst_ack0", last_ack, 32'h0001);
    step(); step();

    // Pointer wrap from 15 to 0.
    raise(14, 0, 1);
    step();
    raise(0, 0, 1); raise(15, 0, 1);
    step(); chk("wrap_ack15", last_ack, 32'h8000);
    step(); chk("wrap_ack0", last_ack, 32'h0001);
    step();

    // Random traffic with locks, abandoned locks, stalls and occasional resets.
    rand_mode = 1;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i]) begin
          if (gap[i] > 0) begin
            gap[i]--;
            if (gap[i] == 0) pend[i] = 1;
          end else if (remain[i] <= 0 && $urandom_range(0, 7) == 0) begin
            if ($urandom_range(0, 3) == 0) raise(i, 1, $urandom_range(2, 7));
            else raise(i, 0, 1);
          end
        end
      end
      stall_v = ($urandom_range(0, 4) == 0);
      step();
      if ($urandom_range(0, 599) == 0) do_reset();
    end

    rand_mode = 0;
    stall_v = 0;
    clr_all();
    step(); step();
    @(negedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
